bus_write_trace: RTL and testbench
==================================

# bus_write_trace

Captures every CPU store cycle on the 6502 bus (address, data) into a small first-word-fall-through FIFO for later drain by a testbench or debug host. It sits directly downstream of `cpu6502`, on the same `addr`/`odata`/`rw`/`clk2` nets that feed ROM/RAM, and replaces hand-placed cycle-counted store assertions with an ordered write log. Overflow is flagged and counted, never silently lost.

## Interface
- `DEPTH_LOG2`, 4, FIFO depth is 2**DEPTH_LOG2 entries (16)
- `clk`  in  1  system clock, same `clk` that drives `cpu6502`
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  16  CPU address bus
- `odata`  in  8  CPU write data bus
- `rw`  in  1  CPU read/write, 0 = write
- `clk2`  in  1  CPU phi2 output
- `match_base`  in  16  address filter base
- `match_mask`  in  16  address filter mask, 1 = bit compared; 0x0000 captures all writes
- `clear`  in  1  synchronous flush of FIFO and status
- `out_valid`  out  1  FIFO non-empty; head entry presented
- `out_ready`  in  1  consumer accepts head entry
- `out_addr`  out  16  head entry address
- `out_data`  out  8  head entry data
- `count`  out  DEPTH_LOG2+1  entries held, 0..DEPTH
- `overflow`  out  1  sticky: at least one write dropped
- `dropped`  out  8  dropped-write counter, saturates at 255

## Operation
- Phi2 edge detect: `clk2_q` registers `clk2` every cycle; `rise = clk2 & ~clk2_q`.
- Capture condition (evaluated each clk edge): `rise & ~rw & ((addr & match_mask) == (match_base & match_mask))`. `addr`/`odata` sampled on that same edge.
- At most one capture per phi2 high phase; a write held across several clk cycles is logged once.
- Push: captured entry written at `mem[wr_ptr]`, `wr_ptr` increments, wraps at DEPTH.
- Pop: `out_valid & out_ready`; `rd_ptr` increments, wraps at DEPTH.
- `out_addr`/`out_data` = `mem[rd_ptr]` (combinational read of register array); undefined content when `out_valid`=0, but must not be X-propagating into `out_valid`/`count`.
- `count` = pushes − pops; pointers carry one extra bit (DEPTH_LOG2+1 wide) to distinguish full from empty.
- Boundary rules:
  - Full, capture, no pop: capture dropped; `overflow`←1; `dropped`←min(`dropped`+1, 255). FIFO contents unchanged.
  - Full, capture, pop same cycle: both occur; new entry stored; `count` stays DEPTH; no drop.
  - Empty, capture: stored; `out_ready` that cycle has no effect (`out_valid` was 0).
  - Capture and pop, not full: both occur; `count` unchanged.
  - `clear` asserted: pointers, `count`, `overflow`, `dropped` → 0; a capture in the same cycle is discarded (clear wins); pop ignored.
  - `reset` has priority over `clear`; reset mid-drain discards all entries.
- `match_base`/`match_mask` may change at any time; take effect on the next capture evaluation.

## Timing
- Reset values: `out_valid`=0, `count`=0, `overflow`=0, `dropped`=0, pointers 0, `clk2_q`=1 (suppresses a false edge if `clk2` is high when reset releases).
- Capture latency: capture evaluated on edge T → `count`, `out_valid` updated after edge T (visible in cycle T+1). If FIFO was empty, `out_addr`/`out_data` show the entry from cycle T+1.
- Pop latency: pop on edge T → next entry (or `out_valid`=0) visible in cycle T+1.
- Back-to-back: consumer holding `out_ready`=1 drains one entry per clk cycle.
- No combinational path from `out_ready` to `out_valid`/`out_addr`/`out_data`.
- Minimum phi2 period supported: 2 clk cycles (one low sample, one high sample).

## Test plan
- Program `LDA #$01; ADC #$FF; STA $99` with mask 0x0000 → exactly one entry (0x0099, 0x00); `count`=1; no entries from opcode/operand fetches (rw=1).
- 17 stores `STA $10..$20` (data = low addr byte) with `out_ready`=0 → `count`=16, entries $10..$1F in order, `overflow`=1, `dropped`=1; drain returns 0x0010..0x001F then `out_valid`=0.
- Full FIFO, hold `out_ready`=1 across a store to $0200 → store accepted, `count` stays 16, `dropped` unchanged, last drained entry (0x0200, data).
- Filter `match_base`=0x0200, `match_mask`=0xFF00; stores to $0099, $0205, $0300 → single entry (0x0205, data).
- 300 stores with `out_ready`=0 → `dropped`=255 (saturated), `overflow`=1; pulse `clear` coincident with a store → `count`=0, `overflow`=0, `dropped`=0, `out_valid`=0 next cycle.
- Assert `reset` with 5 entries queued while draining → cycle after reset: `out_valid`=0, `count`=0; first store after reset logged correctly, with no spurious entry even if `clk2`=1 at reset release.

Source files
------------

// File: rtl/bus_write_trace.sv
// Ordered log of 6502 store cycles: one entry per phi2 high phase with rw=0 that
// passes the address filter, held in a first-word-fall-through FIFO for a drain port.
module bus_write_trace #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           addr,
    input  logic [7:0]            odata,
    input  logic                  rw,
    input  logic                  clk2,
    input  logic [15:0]           match_base,
    input  logic [15:0]           match_mask,
    input  logic                  clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_addr,
    output logic [7:0]            out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            dropped
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic                  clk2_q;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [15:0]           mem_addr [DEPTH];
    logic [7:0]            mem_data [DEPTH];

    logic rise;
    logic addr_hit;
    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // A write held over several clk cycles produces only one rising-edge sample.
    assign rise     = clk2 & ~clk2_q;
    assign addr_hit = (addr & match_mask) == (match_base & match_mask);
    assign capture  = rise & ~rw & addr_hit;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr - rd_ptr;
    assign out_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                       (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // Clear discards both a same-cycle capture and a same-cycle pop.
    assign pop  = out_valid & out_ready & ~clear;
    assign push = capture & (~full | pop) & ~clear;
    assign drop = capture & full & ~pop & ~clear;

    assign out_addr = mem_addr[rd_ptr[DEPTH_LOG2-1:0]];
    assign out_data = mem_data[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk2_q   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            dropped  <= 8'd0;
        end else begin
            clk2_q <= clk2;
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
                dropped  <= 8'd0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (drop) begin
                    overflow <= 1'b1;
                    if (dropped != 8'hFF) dropped <= dropped + 8'd1;
                end
            end
        end
    end

    // Storage has no reset; only entries between the pointers are ever presented.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_addr[wr_ptr[DEPTH_LOG2-1:0]] <= addr;
            mem_data[wr_ptr[DEPTH_LOG2-1:0]] <= odata;
        end
    end

endmodule

// File: tb/tb_bus_write_trace.sv
// Directed bus-cycle stimulus for bus_write_trace, checked every cycle against a
// queue-based write-log model plus hand-computed literal expectations.
module tb_bus_write_trace;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  odata;
    logic        rw;
    logic        clk2;
    logic [15:0] match_base;
    logic [15:0] match_mask;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_addr;
    logic [7:0]  out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  dropped;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    bus_write_trace #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .odata(odata), .rw(rw), .clk2(clk2),
        .match_base(match_base), .match_mask(match_mask), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .count(count), .overflow(overflow), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Model: ordered write log with drop accounting.
    logic [23:0] mq[$];
    bit          mprev;
    bit          movf;
    int          mdrop;
    bit          m_cap;
    bit          m_full;
    bit          m_pop;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mprev = 1'b1;
            movf  = 1'b0;
            mdrop = 0;
        end else begin
            m_cap = clk2 && !mprev && !rw && ((addr & match_mask) == (match_base & match_mask));
            if (clear) begin
                mq.delete();
                movf  = 1'b0;
                mdrop = 0;
            end else begin
                m_full = (mq.size() == 16);
                m_pop  = (mq.size() > 0) && out_ready;
                if (m_pop) void'(mq.pop_front());
                if (m_cap) begin
                    if (!m_full || m_pop) mq.push_back({addr, odata});
                    else begin
                        movf = 1'b1;
                        if (mdrop < 255) mdrop++;
                    end
                end
            end
            mprev = clk2;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", int'(out_valid), int'(mq.size() != 0));
            check("m_count", int'(count), mq.size());
            check("m_overflow", int'(overflow), int'(movf));
            check("m_dropped", int'(dropped), mdrop);
            if (mq.size() != 0) check("m_head", int'({out_addr, out_data}), int'(mq[0]));
        end
    end

    // Phi2 low cycle, then high phase of 'hi' cycles. Ready/clear pulses land on the rising edge.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic wr,
                       input int hi = 1, input logic rdy = 0, input logic clr = 0);
        @(negedge clk);
        clk2 = 0; rw = 1; addr = a; odata = d;
        @(negedge clk);
        clk2 = 1; rw = ~wr; out_ready = rdy; clear = clr;
        for (int i = 1; i < hi; i++) begin
            @(negedge clk);
            out_ready = 0; clear = 0;
        end
        @(negedge clk);
        clk2 = 0; rw = 1; out_ready = 0; clear = 0;
    endtask

    logic [23:0] drained[$];

    task automatic drain();
        drained.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!out_valid) break;
            drained.push_back({out_addr, out_data});
            out_ready = 1;
        end
        out_ready = 0;
        @(negedge clk);
        check("drain_done", int'(out_valid), 0);
    endtask

    initial begin
        reset = 1; clk2 = 1; rw = 1; addr = 16'h0; odata = 8'h0;
        match_base = 16'h0; match_mask = 16'h0; clear = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_count", int'(count), 0);
        check("rst_valid", int'(out_valid), 0);
        reset = 0;

        // LDA #$01; ADC #$FF; STA $99 -> only the store is logged
        bus(16'h0200, 8'hA9, 0); bus(16'h0201, 8'h01, 0);
        bus(16'h0202, 8'h69, 0); bus(16'h0203, 8'hFF, 0);
        bus(16'h0204, 8'h85, 0); bus(16'h0205, 8'h99, 0);
        bus(16'h0099, 8'h00, 1, 3);
        check("prog_count", int'(count), 1);
        check("prog_entry", int'({out_addr, out_data}), 24'h009900);
        drain();
        check("prog_drained", drained.size(), 1);

        // 17 stores into a 16-deep log
        for (int i = 0; i < 17; i++) bus(16'h0010 + 16'(i), 8'h10 + 8'(i), 1);
        check("full_count", int'(count), 16);
        check("full_ovf", int'(overflow), 1);
        check("full_dropped", int'(dropped), 1);
        drain();
        check("full_drained", drained.size(), 16);
        for (int i = 0; i < 16 && i < drained.size(); i++)
            check("full_order", int'(drained[i]), int'({16'h0010 + 16'(i), 8'h10 + 8'(i)}));

        // Full log, pop coincident with a store
        for (int i = 0; i < 16; i++) bus(16'h0030 + 16'(i), 8'(i), 1);
        bus(16'h0200, 8'h5A, 1, 1, 1);
        check("fullpop_count", int'(count), 16);
        check("fullpop_dropped", int'(dropped), 1);
        drain();
        check("fullpop_drained", drained.size(), 16);
        if (drained.size() == 16) begin
            check("fullpop_first", int'(drained[0]), 24'h003101);
            check("fullpop_last", int'(drained[15]), 24'h02005A);
        end

        // Address filter
        match_base = 16'h0200; match_mask = 16'hFF00;
        bus(16'h0099, 8'h11, 1); bus(16'h0205, 8'h22, 1); bus(16'h0300, 8'h33, 1);
        check("filt_count", int'(count), 1);
        check("filt_entry", int'({out_addr, out_data}), 24'h020522);
        drain();
        match_base = 16'h0; match_mask = 16'h0;

        // Saturating drop counter, then clear coincident with a store
        for (int i = 0; i < 300; i++) bus(16'h1000 + 16'(i), 8'(i), 1);
        check("sat_dropped", int'(dropped), 255);
        check("sat_ovf", int'(overflow), 1);
        check("sat_count", int'(count), 16);
        bus(16'h2000, 8'h99, 1, 1, 0, 1);
        check("clr_count", int'(count), 0);
        check("clr_ovf", int'(overflow), 0);
        check("clr_dropped", int'(dropped), 0);
        check("clr_valid", int'(out_valid), 0);

        // Reset mid-drain with phi2 high and a write-looking bus at release
        for (int i = 0; i < 5; i++) bus(16'h0040 + 16'(i), 8'h40 + 8'(i), 1);
        check("pre_rst_count", int'(count), 5);
        @(negedge clk); out_ready = 1;
        @(negedge clk);
        reset = 1; clk2 = 1; rw = 0; addr = 16'h0400; odata = 8'hEE;
        @(negedge clk);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_count", int'(count), 0);
        reset = 0;
        repeat (2) @(negedge clk);
        check("post_rst_count", int'(count), 0);
        out_ready = 0; rw = 1;
        bus(16'h0123, 8'h77, 1);
        check("post_rst_entry_count", int'(count), 1);
        check("post_rst_entry", int'({out_addr, out_data}), 24'h012377);
        drain();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
